muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width in bits (iteration count equals XLEN).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request strobe from EX stage; sampled only in IDLE.
REQ-005 SHALL have port: funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port: op_a  input  XLEN  rs1 operand (multiplicand/dividend).
REQ-007 SHALL have port: op_b  input  XLEN  rs2 operand (multiplier/divisor).
REQ-008 SHALL have port: flush  input  1  pipeline flush; aborts any operation in progress.
REQ-009 SHALL have port: busy  output  1  high while an accepted operation is not yet complete; drives EX stall.
REQ-010 SHALL have port: valid  output  1  one-cycle completion pulse; result valid in that cycle.
REQ-011 SHALL have port: result  output  XLEN  operation result.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE: start=1 and flush=0 SHALL latch funct3, op_a, op_b, take operand magnitudes and result sign, clear the iteration counter, and go to CALC (or DONE per REQ-018/019).
REQ-014 CALC SHALL perform one iteration per cycle: shift-add for MUL*, restoring shift-subtract for DIV*/REM*; counter increments; after XLEN iterations -> DONE.
REQ-015 DONE SHALL assert valid=1 for exactly one cycle, apply sign fixup, drive result, then return to IDLE.
REQ-016 Latency SHALL be XLEN+1 cycles from the start-sampling edge to the edge ending the valid cycle (33 for XLEN=32); busy=1 in CALC, 0 in IDLE and DONE.
REQ-017 Signedness: MUL/MULH/DIV/REM treat both operands signed; MULHSU op_a signed, op_b unsigned; MULHU/DIVU/REMU unsigned. MUL returns low XLEN bits of the 2*XLEN product; MULH* return the high XLEN bits.
REQ-018 Divide by zero (op_b=0) SHALL skip CALC (IDLE->DONE): DIV/DIVU result all-ones, REM/REMU result = op_a.
REQ-019 Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF) SHALL skip CALC: DIV result 0x80000000, REM result 0.
REQ-020 Remainder sign SHALL follow dividend; quotient SHALL truncate toward zero.
REQ-021 start while not IDLE SHALL be ignored; operands changing after acceptance SHALL NOT affect the result.
REQ-022 flush=1 in any state SHALL force IDLE on the next edge, suppress valid for the aborted op, and leave result unchanged; flush and start together in IDLE SHALL NOT accept.
REQ-023 result SHALL hold its last value between completions; valid SHALL never be asserted twice per accepted op.
REQ-024 Internal accumulator SHALL be 2*XLEN+1 bits; the counter SHALL be clog2(XLEN)+1 bits and never wrap during CALC.

Reset
REQ-025 rst_n=0 SHALL immediately (asynchronously) force state IDLE, busy=0, valid=0, result=0, counter=0, including mid-CALC; operation resumes only via a new start after rst_n=1.

Verification
REQ-026 MUL 7 x -3 (op_b=0xFFFFFFFD): start at cycle 0 -> busy 1..32, valid at cycle 33, result=0xFFFFFFEB.
REQ-027 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-028 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-029 DIVU 5/0 -> valid one cycle after start, busy never high, result=0xFFFFFFFF; REM 0x80000000/0xFFFFFFFF -> result 0.
REQ-030 flush at cycle 10 of a DIV -> IDLE at cycle 11, no valid, result unchanged; new start at cycle 12 completes normally at cycle 45.
REQ-031 rst_n low at cycle 15 of a MUL -> busy=0, valid=0, result=0 without clock edge; start during CALC ignored (no second valid).

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
// Operands are converted to magnitudes on acceptance; the sign is applied once,
// on the final step, so the result register only changes when valid rises.
// Divide-by-zero and signed overflow bypass the iterative datapath entirely.
//
// Handshake: start is sampled only in IDLE and only when flush is low. Once
// accepted, busy is high for the XLEN iteration cycles. valid is a single-cycle
// pulse in DONE, and result is good in that cycle and held until the next
// completion. flush or rst_n abandon the operation without a valid pulse.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result,
    output logic [1:0]      dbg_state
);

    localparam int AW = 2 * XLEN + 1;
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] addend_q, addend_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] result_q, result_d;

    // Operand decode, single-step datapath and final sign fixup
    logic            is_div, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] special_res;
    logic [XLEN:0]   mul_sum;
    logic [AW-1:0]   mul_next, div_shift, div_next, acc_step;
    logic [XLEN+1:0] div_diff;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quot, rem, final_res;

    // Next-state, datapath and output computation
    always_comb begin
        is_div   = funct3[2];
        a_signed = is_div ? ~funct3[0] : (funct3 != 3'b011);
        b_signed = is_div ? ~funct3[0] : ~funct3[1];
        a_neg    = a_signed & op_a[XLEN-1];
        b_neg    = b_signed & op_b[XLEN-1];
        mag_a    = a_neg ? -op_a : op_a;
        mag_b    = b_neg ? -op_b : op_b;
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && ~funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        if (div_zero) begin
            special_res = funct3[1] ? op_a : '1;
        end else begin
            special_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end

        // Multiply: conditionally add multiplicand to the upper half, shift right
        mul_sum  = acc_q[AW-1:XLEN] + (acc_q[0] ? {1'b0, addend_q} : '0);
        mul_next = {1'b0, mul_sum, acc_q[XLEN-1:1]};
        // Divide: shift left, trial-subtract divisor, keep if no borrow
        div_shift = {acc_q[AW-2:0], 1'b0};
        div_diff  = {1'b0, div_shift[AW-1:XLEN]} - {2'b00, addend_q};
        div_next  = div_diff[XLEN+1] ? div_shift
                                     : {div_diff[XLEN:0], div_shift[XLEN-1:1], 1'b1};
        acc_step  = op_q[2] ? div_next : mul_next;

        prod     = acc_step[2*XLEN-1:0];
        prod_fix = neg_q ? -prod : prod;
        quot     = acc_step[XLEN-1:0];
        rem      = acc_step[2*XLEN-1:XLEN];
        if (!op_q[2]) begin
            final_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (op_q[1]) begin
            final_res = neg_q ? -rem : rem;
        end else begin
            final_res = neg_q ? -quot : quot;
        end

        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        addend_d = addend_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d  = funct3;
                    cnt_d = '0;
                    if (is_div) begin
                        neg_d    = funct3[1] ? a_neg : (a_neg ^ b_neg);
                        addend_d = mag_b;
                        acc_d    = {{(XLEN+1){1'b0}}, mag_a};
                    end else begin
                        neg_d    = (funct3 == 3'b010) ? a_neg : (a_neg ^ b_neg);
                        addend_d = mag_a;
                        acc_d    = {{(XLEN+1){1'b0}}, mag_b};
                    end
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) begin
                    result_d = final_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush abandons whatever is in flight and never updates result
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end

        busy_d  = (state_d == CALC);
        valid_d = (state_d == DONE);
    end

    // State, datapath and registered outputs with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            addend_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            addend_q <= addend_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: an arithmetic reference model plus a cycle
// timeline (when busy/valid must be high) checked on every falling edge.
module tb_muldiv_seq;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, valid;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .valid(valid), .result(result), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];
  int due = -1;          // cycle in which valid must be high
  int bfrom = 0;         // busy window [bfrom, bto]
  int bto = -1;
  logic [31:0] last_res = '0;
  logic exp_v, exp_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  // Reference arithmetic straight from the RV32M definitions
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p = '0;
    q = 0;
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == MIN_INT && b == '1) return MIN_INT;
        q = $signed(a) / $signed(b);
        return 32'(q);
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_INT && b == '1) return '0;
        q = $signed(a) % $signed(b);
        return 32'(q);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == MIN_INT && b == '1));
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    exp_v = (cyc == due);
    exp_b = (cyc >= bfrom) && (cyc <= bto);
    if (!rst_n) last_res = '0;
    check("valid", 32'(valid), 32'(exp_v));
    check("busy", 32'(busy), 32'(exp_b));
    if (exp_v && exp_q.size() > 0) begin
      check("result", result, exp_q[0]);
      last_res = exp_q[0];
    end else begin
      check("result_hold", result, last_res);
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    exp_q.push_back(model(f, a, b));
    if (is_fast(f, a, b)) begin
      due = cyc + 1;
      bfrom = 0;
      bto = -1;
    end else begin
      due = cyc + XLEN + 1;
      bfrom = cyc + 1;
      bto = cyc + XLEN;
    end
    step();
    start  = 1'b0;
    funct3 = 3'($urandom_range(0, 7));
    op_a   = $urandom;
    op_b   = $urandom;
  endtask

  task automatic finish_op(input logic [31:0] lit, input bit use_lit);
    for (int i = 0; i < 40 && cyc <= due; i++) step();
    if (cyc <= due) begin
      n_checks++;
      $display("FAIL timeout at cycle %0d: still waiting for cycle %0d", cyc, due);
    end
    if (use_lit) check("literal", result, lit);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lit, input bit use_lit);
    launch(f, a, b);
    finish_op(lit, use_lit);
  endtask

  // ---------------- stimulus ----------------
  int c0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 32'h0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    step();

    do_op(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);  // MUL 7 * -3
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1); // MULHU
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1); // MULH
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); // MULHSU
    do_op(3'd0, MIN_INT,       32'hFFFF_FFFF, 32'h8000_0000, 1'b1); // MUL min * -1
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b1); // DIV -7/2
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b1); // REM -7/2
    do_op(3'd5, 32'd100,       32'd7,         32'd14,        1'b1); // DIVU
    do_op(3'd7, 32'd100,       32'd7,         32'd2,         1'b1); // REMU
    do_op(3'd4, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b1); // DIV 100/-7
    do_op(3'd6, 32'd100,       32'hFFFF_FFF9, 32'd2,         1'b1); // REM 100/-7
    do_op(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1); // DIVU by zero
    do_op(3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1); // DIV by zero
    do_op(3'd7, 32'd9,         32'd0,         32'd9,         1'b1); // REMU by zero
    do_op(3'd6, MIN_INT,       32'hFFFF_FFFF, 32'd0,         1'b1); // REM overflow
    do_op(3'd4, MIN_INT,       32'hFFFF_FFFF, MIN_INT,       1'b1); // DIV overflow
    do_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, '0, 1'b0);
    do_op(3'd2, 32'h8000_0001, 32'hF000_0000, '0, 1'b0);
    do_op(3'd7, 32'hDEAD_BEEF, 32'h0000_1234, '0, 1'b0);

    // flush in the middle of a DIV, then a fresh op two cycles later
    c0 = cyc;
    launch(3'd4, 32'd1000, 32'd7);
    while (cyc < c0 + 10) step();
    flush = 1'b1;
    due = -1;
    bto = cyc;
    step();
    flush = 1'b0;
    check("flush_idle", 32'(dbg_state), 32'd0);
    void'(exp_q.pop_front());
    step();
    do_op(3'd4, 32'd1000, 32'd7, 32'd142, 1'b1);

    // start pulses during CALC must be ignored
    c0 = cyc;
    launch(3'd0, 32'd123, 32'd456);
    while (cyc < c0 + 5) step();
    start = 1'b1;
    funct3 = 3'd5;
    op_b = 32'd0;
    step();
    start = 1'b0;
    finish_op(32'd56088, 1'b1);
    repeat (3) step();

    // asynchronous reset in the middle of a MUL
    c0 = cyc;
    launch(3'd0, 32'd7, 32'hFFFF_FFFD);
    while (cyc < c0 + 15) step();
    #2;
    rst_n = 1'b0;
    due = -1;
    bto = -1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_result", result, 32'd0);
    void'(exp_q.pop_front());
    step();
    step();
    rst_n = 1'b1;
    repeat (40) step();
    do_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
